// File: rtl/prt_riscv_ram_arb.sv
// Round-robin arbiter sharing one single-port data RAM between CPU (M0) and host (M1); ACK is combinational.
// Read returns come out one cycle after RAM_RD_VLD_IN; a read stalls without ACK while the tag FIFO is full.
module prt_riscv_ram_arb #(
  parameter int P_ADR      = 16,
  parameter int P_RD_DEPTH = 4
) (
  input  logic             CLK_IN,
  input  logic             RST_IN,
  input  logic [P_ADR-1:0] M0_ADR_IN,
  input  logic             M0_WR_IN,
  input  logic             M0_RD_IN,
  input  logic [31:0]      M0_WR_DAT_IN,
  input  logic [3:0]       M0_WR_STRB_IN,
  output logic             M0_ACK_OUT,
  output logic             M0_RD_VLD_OUT,
  output logic [31:0]      M0_RD_DAT_OUT,
  input  logic [P_ADR-1:0] M1_ADR_IN,
  input  logic             M1_WR_IN,
  input  logic             M1_RD_IN,
  input  logic [31:0]      M1_WR_DAT_IN,
  input  logic [3:0]       M1_WR_STRB_IN,
  output logic             M1_ACK_OUT,
  output logic             M1_RD_VLD_OUT,
  output logic [31:0]      M1_RD_DAT_OUT,
  output logic [P_ADR-1:0] RAM_ADR_OUT,
  output logic             RAM_WR_OUT,
  output logic             RAM_RD_OUT,
  output logic [31:0]      RAM_WR_DAT_OUT,
  output logic [3:0]       RAM_WR_STRB_OUT,
  input  logic             RAM_RD_VLD_IN,
  input  logic [31:0]      RAM_RD_DAT_IN,
  output logic             STA_ERR_OUT
);

  localparam int PW = $clog2(P_RD_DEPTH);
  localparam logic [PW:0] FULL_CNT = P_RD_DEPTH[PW:0];

  logic [P_RD_DEPTH-1:0] tag_mem;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           cnt;
  logic                  prio_m1;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  m0_elig;
  logic                  m1_elig;
  logic                  m0_gnt;
  logic                  m1_gnt;
  logic                  push;
  logic                  pop;
  logic                  head_tag;
  logic                  err_evt;

  assign fifo_full  = (cnt == FULL_CNT);
  assign fifo_empty = (cnt == '0);

  // Eligibility looks at the registered count, so a same-cycle pop never frees a slot early.
  assign m0_elig = M0_WR_IN | (M0_RD_IN & ~fifo_full);
  assign m1_elig = M1_WR_IN | (M1_RD_IN & ~fifo_full);
  assign m0_gnt  = m0_elig & (~m1_elig | ~prio_m1);
  assign m1_gnt  = m1_elig & (~m0_elig | prio_m1);

  assign M0_ACK_OUT = m0_gnt;
  assign M1_ACK_OUT = m1_gnt;

  always_comb begin
    RAM_ADR_OUT     = M0_ADR_IN;
    RAM_WR_DAT_OUT  = M0_WR_DAT_IN;
    RAM_WR_STRB_OUT = M0_WR_STRB_IN;
    RAM_WR_OUT      = 1'b0;
    RAM_RD_OUT      = 1'b0;
    if (m1_gnt) begin
      RAM_ADR_OUT     = M1_ADR_IN;
      RAM_WR_DAT_OUT  = M1_WR_DAT_IN;
      RAM_WR_STRB_OUT = M1_WR_STRB_IN;
      RAM_WR_OUT      = M1_WR_IN;
      RAM_RD_OUT      = M1_RD_IN & ~M1_WR_IN;
    end else if (m0_gnt) begin
      RAM_WR_OUT = M0_WR_IN;
      RAM_RD_OUT = M0_RD_IN & ~M0_WR_IN;
    end
  end

  assign push     = RAM_RD_OUT;
  assign pop      = RAM_RD_VLD_IN & ~fifo_empty;
  assign head_tag = tag_mem[rd_ptr];
  assign err_evt  = (RAM_RD_VLD_IN & fifo_empty) | (M0_RD_IN & M0_WR_IN) | (M1_RD_IN & M1_WR_IN);

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      tag_mem       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      prio_m1       <= 1'b0;
      M0_RD_VLD_OUT <= 1'b0;
      M1_RD_VLD_OUT <= 1'b0;
      M0_RD_DAT_OUT <= '0;
      M1_RD_DAT_OUT <= '0;
      STA_ERR_OUT   <= 1'b0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= m1_gnt;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // Loser of this cycle gets the next tie.
      if (m0_gnt | m1_gnt) begin
        prio_m1 <= m0_gnt;
      end
      M0_RD_VLD_OUT <= pop & ~head_tag;
      M1_RD_VLD_OUT <= pop & head_tag;
      if (pop & ~head_tag) begin
        M0_RD_DAT_OUT <= RAM_RD_DAT_IN;
      end
      if (pop & head_tag) begin
        M1_RD_DAT_OUT <= RAM_RD_DAT_IN;
      end
      if (err_evt) begin
        STA_ERR_OUT <= 1'b1;
      end
    end
  end

endmodule
